// File: rtl/bit_count_pkg.sv
// Shared types for the bit-statistics engine: count modes and FSM states.
package bit_count_pkg;

  typedef enum logic [1:0] {
    MODE_POP1 = 2'd0,
    MODE_POP0 = 2'd1,
    MODE_LZC  = 2'd2,
    MODE_TZC  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_count_chunk.sv
// Combinational evaluation of one CHUNK-bit slice: population count,
// number of zeros before the first 1 in the chosen scan direction, and
// whether the slice contains any 1 at all.
module bit_count_chunk #(
  parameter int CHUNK = 8,
  localparam int CCW = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  input  logic             from_msb,
  output logic [CCW-1:0]   ones,
  output logic [CCW-1:0]   lead,
  output logic             hit
);

  // Single pass: count ones everywhere, count zeros only until the first 1.
  always_comb begin
    ones = '0;
    lead = '0;
    hit  = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + CCW'(bits[i]);
      if (!hit) begin
        if (bits[from_msb ? (CHUNK - 1 - i) : i]) hit = 1'b1;
        else                                      lead = lead + CCW'(1);
      end
    end
  end

endmodule

// File: rtl/bit_count_unit.sv
// Multi-cycle bit-statistics engine. A word accepted in IDLE is scanned
// CHUNK bits per cycle; the count is presented in DONE until consumed.
//
//   state | meaning
//   IDLE  | Ready high, waiting for a request
//   COUNT | one chunk accumulated per cycle, early exit on LZC/TZC hit
//   DONE  | OutValid high, result held until OutReady
module bit_count_unit
  import bit_count_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] DataIn,
  output logic             Ready,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CW-1:0]    DataOut
);

  localparam int N   = WIDTH / CHUNK;
  localparam int CCW = $clog2(CHUNK + 1);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("bit_count_unit: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  state_e           state, state_nxt;
  mode_e            mode_q;
  logic [WIDTH-1:0] word_q;
  logic [IW-1:0]    idx, phys;
  logic [CW-1:0]    acc, acc_nxt, add_v, dout;
  logic [CHUNK-1:0] chunk_bits;
  logic [CCW-1:0]   c_ones, c_lead;
  logic             c_hit, last, stop;

  // LZC walks chunks from the top of the word; every other mode from the bottom.
  always_comb begin
    phys = (mode_q == MODE_LZC) ? (IW'(N - 1) - idx) : idx;
    chunk_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (phys == IW'(i)) chunk_bits = word_q[i*CHUNK +: CHUNK];
    end
  end

  bit_count_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits     (chunk_bits),
    .from_msb (mode_q == MODE_LZC),
    .ones     (c_ones),
    .lead     (c_lead),
    .hit      (c_hit)
  );

  // Per-chunk contribution and the early-termination decision.
  always_comb begin
    case (mode_q)
      MODE_POP1: add_v = CW'(c_ones);
      MODE_POP0: add_v = CW'(CHUNK) - CW'(c_ones);
      default:   add_v = c_hit ? CW'(c_lead) : CW'(CHUNK);
    endcase
    acc_nxt = acc + add_v;
    last    = (idx == IW'(N - 1));
    stop    = last || (c_hit && (mode_q == MODE_LZC || mode_q == MODE_TZC));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    OutValid  = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Valid) state_nxt = COUNT;
      end
      COUNT: begin
        if (stop) state_nxt = DONE;
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture request, accumulate, and latch the result on entry to DONE.
  // dout is separate from acc so the last result survives the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      mode_q <= MODE_POP1;
      idx    <= '0;
      acc    <= '0;
      dout   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Valid) begin
            word_q <= DataIn;
            mode_q <= mode_e'(Mode);
            idx    <= '0;
            acc    <= '0;
          end
        end
        COUNT: begin
          acc <= acc_nxt;
          if (stop) dout <= acc_nxt;
          else      idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign DataOut = dout;

endmodule
